// File: rtl/aes_pkg.sv
// Shared AES types and byte-level helpers used by the key schedule and the cipher datapaths.
package aes_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  typedef enum logic {IDLE, EXPAND} ks_state_t;

  localparam byte_t RCON_INIT = 8'h01;
  localparam byte_t RCON_POLY = 8'h1b;

  // Forward S-box, row-major; entry b occupies bits [8*b +: 8] counting from the left.
  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

  function automatic byte_t sbox(input byte_t b);
    return SBOX_TABLE[8*b +: 8];
  endfunction

endpackage

// File: rtl/keyexpansion_seq_if.sv
// Key-schedule request/result bundle between a requester and the sequential expansion engine.
interface keyexpansion_seq_if #(
    parameter int Nk = 4,
    parameter int Nr = 10
);
    localparam int Nw = 4 * (Nr + 1);

    logic                start;
    logic [0:32*Nk-1]    key;
    logic                busy;
    logic                done;
    logic                valid;
    logic [0:32*Nw-1]    w;

    modport master (output start, key, input busy, done, valid, w);
    modport slave  (input start, key, output busy, done, valid, w);
endinterface

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
module aes_sbox
    import aes_pkg::*;
(
    input  byte_t a,
    output byte_t y
);
    assign y = sbox(a);
endmodule

// File: rtl/keyexpansion_seq.sv
// Sequential AES key expansion: one schedule word per clock into a flat register array.
module keyexpansion_seq
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    keyexpansion_seq_if.slave  bus
);
    localparam int Nw = 4 * (Nr + 1);
    localparam int IW = $clog2(Nw + 1);
    localparam int PW = $clog2(Nk + 1);
    localparam logic [IW-1:0] I_LAST = IW'(Nw - 1);
    localparam logic [PW-1:0] P_LAST = PW'(Nk - 1);
    localparam logic [PW-1:0] P_SUB  = PW'(4);
    localparam bit            SUB4   = (Nk > 6);

    ks_state_t       state, state_d;
    logic [IW-1:0]   i;
    logic [PW-1:0]   p;
    byte_t           rcon;
    logic            busy_q, done_q, valid_q;
    word_t           sched [Nw];

    logic            load, step, last;
    word_t           prev, sub_in, sub_out, t, nxt;

    always_comb begin
        state_d = state;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                step = 1'b1;
                if (i == I_LAST) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Phase 0 rotates before substitution; the AES-256 mid-key phase substitutes only.
    assign prev   = sched[i - IW'(1)];
    assign sub_in = (p == '0) ? {prev[23:0], prev[31:24]} : prev;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .y(sub_out[8*b +: 8]));
    end

    always_comb begin
        if (p == '0)
            t = sub_out ^ {rcon, 24'h0};
        else if (SUB4 && p == P_SUB)
            t = sub_out;
        else
            t = prev;
        nxt = sched[i - IW'(Nk)] ^ t;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            i       <= '0;
            p       <= '0;
            rcon    <= RCON_INIT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            for (int j = 0; j < Nw; j++) sched[j] <= '0;
        end else begin
            state  <= state_d;
            done_q <= last;
            if (load) begin
                for (int j = 0; j < Nk; j++) sched[j] <= bus.key[32*j +: 32];
                i       <= IW'(Nk);
                p       <= '0;
                rcon    <= RCON_INIT;
                valid_q <= 1'b0;
                busy_q  <= 1'b1;
            end
            if (step) begin
                sched[i] <= nxt;
                i        <= i + IW'(1);
                p        <= (p == P_LAST) ? '0 : p + PW'(1);
                if (p == '0) rcon <= xtime(rcon);
            end
            if (last) begin
                valid_q <= 1'b1;
                busy_q  <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int j = 0; j < Nw; j++) bus.w[32*j +: 32] = sched[j];
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_keyexpansion_seq.sv
// Bench for keyexpansion_seq: AES-128/192/256 schedules, timing, restart, abort, and downstream decrypt.
module tb_keyexpansion_seq;
    import aes_pkg::*;

    localparam logic [127:0] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] KEY192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] CT     = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT     = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keyexpansion_seq_if #(.Nk(4), .Nr(10)) bus128 ();
    keyexpansion_seq_if #(.Nk(6), .Nr(12)) bus192 ();
    keyexpansion_seq_if #(.Nk(8), .Nr(14)) bus256 ();

    keyexpansion_seq #(.Nk(4), .Nr(10)) dut128 (.clk(clk), .rst_n(rst_n), .bus(bus128));
    keyexpansion_seq #(.Nk(6), .Nr(12)) dut192 (.clk(clk), .rst_n(rst_n), .bus(bus192));
    keyexpansion_seq #(.Nk(8), .Nr(14)) dut256 (.clk(clk), .rst_n(rst_n), .bus(bus256));

    int passed = 0;
    int total  = 0;
    byte_t inv_sb [256];

    typedef struct {
        int          inst;
        int          idx;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [19];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] get_word(input int inst, input int idx);
        case (inst)
            0:       return bus128.w[32*idx +: 32];
            1:       return bus192.w[32*idx +: 32];
            default: return bus256.w[32*idx +: 32];
        endcase
    endfunction

    function automatic byte_t gmul(input byte_t a, input byte_t b);
        byte_t acc = 8'h00;
        byte_t x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc ^= x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Straightforward AES-128 inverse cipher; round r key bytes sit at ks[128*r +: 128].
    function automatic logic [127:0] inv_cipher128(input logic [0:32*44-1] ks, input logic [127:0] ct);
        byte_t s [16];
        byte_t t [16];
        byte_t a0, a1, a2, a3;
        logic [127:0] out;
        for (int k = 0; k < 16; k++) s[k] = ct[127-8*k -: 8] ^ ks[128*10 + 8*k +: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    t[4*c+rr] = inv_sb[s[4*((c - rr + 4) % 4) + rr]];
            for (int k = 0; k < 16; k++) s[k] = t[k] ^ ks[128*r + 8*k +: 8];
            if (r > 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
                    s[4*c+1] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
                    s[4*c+2] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
                    s[4*c+3] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
                end
            end
        end
        for (int k = 0; k < 16; k++) out[127-8*k -: 8] = s[k];
        return out;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy128"},  bus128.busy,  0);
        check({tag, "_done128"},  bus128.done,  0);
        check({tag, "_valid128"}, bus128.valid, 0);
        check({tag, "_w128"},     (bus128.w == '0), 1);
        check({tag, "_busy192"},  bus192.busy,  0);
        check({tag, "_valid192"}, bus192.valid, 0);
        check({tag, "_w192"},     (bus192.w == '0), 1);
        check({tag, "_busy256"},  bus256.busy,  0);
        check({tag, "_valid256"}, bus256.valid, 0);
        check({tag, "_w256"},     (bus256.w == '0), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int n, dones, done_n;
        int done_at [3];
        int done_cnt [3];

        vecs[0]  = '{0, 0,  32'h2b7e1516};
        vecs[1]  = '{0, 3,  32'h09cf4f3c};
        vecs[2]  = '{0, 4,  32'ha0fafe17};
        vecs[3]  = '{0, 5,  32'h88542cb1};
        vecs[4]  = '{0, 6,  32'h23a33939};
        vecs[5]  = '{0, 7,  32'h2a6c7605};
        vecs[6]  = '{0, 40, 32'hd014f9a8};
        vecs[7]  = '{0, 41, 32'hc9ee2589};
        vecs[8]  = '{0, 42, 32'he13f0cc8};
        vecs[9]  = '{0, 43, 32'hb6630ca6};
        vecs[10] = '{1, 0,  32'h8e73b0f7};
        vecs[11] = '{1, 6,  32'hfe0c91f7};
        vecs[12] = '{1, 7,  32'h2402f5a5};
        vecs[13] = '{1, 51, 32'h01002202};
        vecs[14] = '{2, 7,  32'h0914dff4};
        vecs[15] = '{2, 8,  32'h9ba35411};
        vecs[16] = '{2, 9,  32'h8e6925af};
        vecs[17] = '{2, 12, 32'ha8b09c1a};
        vecs[18] = '{2, 59, 32'h706c631e};

        for (int v = 0; v < 256; v++) inv_sb[sbox(byte_t'(v))] = byte_t'(v);

        bus128.start = 1'b0; bus128.key = '0;
        bus192.start = 1'b0; bus192.key = '0;
        bus256.start = 1'b0; bus256.key = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All three key sizes expanded side by side
        bus128.key = KEY128; bus192.key = KEY192; bus256.key = KEY256;
        bus128.start = 1'b1; bus192.start = 1'b1; bus256.start = 1'b1;
        @(posedge clk); #1;
        bus128.start = 1'b0; bus192.start = 1'b0; bus256.start = 1'b0;
        bus128.key = '1; bus192.key = '1; bus256.key = '1;
        check("busy_at_E0_128", bus128.busy, 1);
        check("busy_at_E0_192", bus192.busy, 1);
        check("busy_at_E0_256", bus256.busy, 1);
        done_at = '{-1, -1, -1};
        done_cnt = '{0, 0, 0};
        for (n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (bus128.done) begin done_cnt[0]++; if (done_at[0] < 0) done_at[0] = n; end
            if (bus192.done) begin done_cnt[1]++; if (done_at[1] < 0) done_at[1] = n; end
            if (bus256.done) begin done_cnt[2]++; if (done_at[2] < 0) done_at[2] = n; end
            if (n == 40) begin
                check("busy_low_at_done128", bus128.busy, 0);
                check("valid_at_done128", bus128.valid, 1);
            end
            if (n == 39) check("valid_before_done128", bus128.valid, 0);
        end
        check("done_latency128", done_at[0], 40);
        check("done_latency192", done_at[1], 46);
        check("done_latency256", done_at[2], 52);
        check("done_pulses128", done_cnt[0], 1);
        check("done_pulses192", done_cnt[1], 1);
        check("done_pulses256", done_cnt[2], 1);
        check("valid_hold192", bus192.valid, 1);
        check("valid_hold256", bus256.valid, 1);

        for (int k = 0; k < 19; k++)
            check($sformatf("sched_i%0d_w%0d", vecs[k].inst, vecs[k].idx),
                  get_word(vecs[k].inst, vecs[k].idx), vecs[k].exp);

        check("inv_cipher_run1", inv_cipher128(bus128.w, CT), PT);

        // Start held high with key churning during expansion
        bus128.key = KEY128;
        bus128.start = 1'b1;
        @(posedge clk); #1;
        n = 0; dones = 0; done_n = -1;
        while (n < 60 && done_n < 0) begin
            bus128.key = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            n++;
            if (bus128.done) begin dones++; done_n = n; end
        end
        check("hold_done_latency", done_n, 40);
        check("hold_w4", bus128.w[32*4 +: 32], 32'ha0fafe17);
        check("hold_w43", bus128.w[32*43 +: 32], 32'hb6630ca6);
        check("hold_inv_cipher", inv_cipher128(bus128.w, CT), PT);
        @(posedge clk); #1;
        bus128.start = 1'b0;
        check("restart_valid_drop", bus128.valid, 0);
        check("restart_busy", bus128.busy, 1);
        check("restart_no_done", bus128.done, 0);
        dones = 0;
        for (n = 1; n <= 50; n++) begin
            @(posedge clk); #1;
            if (bus128.done) dones++;
        end
        check("restart_done_pulses", dones, 1);

        // Abort mid-expansion, then a clean run
        bus128.key = KEY128;
        bus128.start = 1'b1;
        @(posedge clk); #1;
        bus128.start = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        @(posedge clk); #1;
        check("abort_hold_w128", (bus128.w == '0), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus128.start = 1'b1;
        @(posedge clk); #1;
        bus128.start = 1'b0;
        n = 0;
        while (n < 100 && !bus128.done) begin
            @(posedge clk); #1;
            n++;
        end
        check("post_abort_latency", n, 40);
        check("post_abort_w4", bus128.w[32*4 +: 32], 32'ha0fafe17);
        check("post_abort_w43", bus128.w[32*43 +: 32], 32'hb6630ca6);
        check("post_abort_inv_cipher", inv_cipher128(bus128.w, CT), PT);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/keyexpansion_seq.md
# keyexpansion_seq

Sequential AES key-schedule engine that sits directly upstream of the combinational inverse cipher. On a start pulse it captures a cipher key and generates the full round-key schedule `w`, one 32-bit word per clock. It presents the schedule as a single flat vector with the same bit ordering the inverse cipher consumes, plus a valid flag. It replaces the fully combinational key expansion wherever area or timing closure matters.

## Interface
- `Nk`, 4: key length in 32-bit words (4 / 6 / 8 for AES-128 / 192 / 256).
- `Nr`, 10: round count (10 / 12 / 14); must be consistent with `Nk`.
- `Nw` (localparam), `4*(Nr+1)`: total schedule words.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: request expansion; sampled only in IDLE.
- `key`  in  `32*Nk`, `[0:32*Nk-1]`: cipher key; word 0 is bits `[0:31]`.
- `busy`  out  1: expansion in progress.
- `done`  out  1: one-cycle pulse when the last word is written.
- `valid`  out  1: the `w` output holds a complete schedule for the last captured key.
- `w`  out  `32*Nw`, `[0:32*Nw-1]`: schedule; word i is `w[32*i +: 32]`.

## Operation
- FSM states: IDLE and EXPAND.
- IDLE with `start=1`:
  - Load `key` into words 0..Nk-1.
  - Set word index `i=Nk`, phase counter `p=0`, `rcon=8'h01`.
  - Clear `valid`, set `busy`, go to EXPAND.
- EXPAND, one word per cycle. Let `t = w[i-1]`.
  - If `p==0`: `t = SubWord(RotWord(t)) ^ {rcon,24'h0}`, and `rcon <= xtime(rcon)`.
  - Else if `Nk>6` and `p==4`: `t = SubWord(t)`.
  - Write `w[i] = w[i-Nk] ^ t`.
  - Update counters: `i++`; `p = (p==Nk-1) ? 0 : p+1`. The phase counter replaces any modulo operator.
- `xtime` is GF(2^8) doubling: shift left, then XOR `8'h1b` if bit 7 was set. So `rcon` steps 01,02,…,80,1b,36.
- `RotWord` maps {a0,a1,a2,a3} to {a1,a2,a3,a0}. `SubWord` applies the forward S-box to each byte: four parallel lookups per cycle.
- When `i==Nw-1` is written:
  - Pulse `done`, set `valid`, clear `busy`, return to IDLE.
- Boundary conditions:
  - `start` during EXPAND is ignored. `key` changes after capture have no effect.
  - `start` held high in IDLE immediately after done restarts expansion; `valid` drops on that same edge.
  - `rst_n` low mid-expansion aborts: all state returns to reset values, and the partial schedule is discarded.
  - `w` words at index ≥ i are stale during EXPAND and are qualified only by `valid`.

## Timing
- Reset values:
  - `busy=0`, `done=0`, `valid=0`, `w=0`.
  - FSM in IDLE; `i=0`, `p=0`, `rcon=8'h01`.
- The key is captured on edge E0, where `start` is sampled in IDLE. `busy` is high from E0.
- `w[Nk+k]` is written on edge E0+1+k.
- The last word is written on edge E0+(Nw-Nk). On that edge `done` and `valid` go high and `busy` goes low.
  - Nw-Nk = 40 for AES-128, 46 for AES-192, 52 for AES-256.
- `done` is high for exactly one cycle. `valid` stays high until the next accepted `start` or reset.
- No combinational path from any input to any output.

## Structure
- Shared package `aes_pkg`:
  - `xtime` function.
  - Rcon initial constant `8'h01` and reduction constant `8'h1b`.
  - Word/byte typedefs.
- Sub-module `aes_sbox`: combinational forward S-box, 8-bit in, 8-bit out. Instantiated four times here; reusable by the forward cipher.
- The top level holds the FSM, the `i`/`p`/`rcon` counters, and the schedule register array.

## Test plan
- AES-128, key `2b7e151628aed2a6abf7158809cf4f3c`, start pulse:
  - `w[4]=a0fafe17`, `w[43]=b6630ca6`.
  - `done` exactly 40 cycles after E0.
- AES-192 (Nk=6, Nr=12), key `8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b`:
  - `w[51]=01002202`; done at E0+46.
- AES-256 (Nk=8, Nr=14), key `603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4`:
  - `w[8]=9ba35411`, `w[59]=706c631e` (exercises the p==4 SubWord path); done at E0+52.
- Start asserted continuously and key changed every cycle during EXPAND:
  - Result still equals the schedule of the key captured at E0.
  - Only one `done` pulse per expansion.
- `rst_n` dropped at E0+20, then a new start with the A.1 key:
  - All outputs are 0 during reset.
  - The second run produces the correct full schedule.
- Downstream check: drive the inverse cipher with `w` after `valid`, A.1 key, ciphertext `3925841d02dc09fbdc118597196a0b32` -> output `3243f6a8885a308d313198a2e0370734`.
